// File: rtl/fx2_slave_fifo_writer.sv
// Transmit engine for the FX2 slave-FIFO IN endpoint: turns a valid/ready word stream into
// FD/SLWR/PKTEND pin activity, flushing short packets on last, idle timeout or disable.
module fx2_slave_fifo_writer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned PKT_WORDS  = 256,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [1:0]  FIFOADR_IN = 2'b10
) (
  input  logic              xIFCLK,
  input  logic              RST,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] FD_O,
  output logic              FD_OE,
  output logic              SLWR_N,
  output logic              PKTEND_N,
  output logic [1:0]        FIFOADR,
  input  logic              AFULL_N,
  output logic              busy_o
);

  localparam int unsigned WcntW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned TcntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WcntW-1:0] WcntLast = WcntW'(PKT_WORDS - 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StGap, StPend} state_e;

  state_e            state_q, state_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;
  logic [TcntW-1:0]  tcnt_q, tcnt_d;
  logic [TcntW-1:0]  tcnt_inc;
  logic              afull_q;
  logic              slwr_n_q, slwr_n_d;
  logic              pktend_n_q, pktend_n_d;
  logic              fd_oe_q, fd_oe_d;
  logic [DATA_W-1:0] fd_o_q, fd_o_d;
  logic              accept;
  logic              wrap;

  // afull_q is one cycle stale; the FX2 flag margin absorbs the one extra accept.
  assign ready_o  = (state_q == StWrite) && afull_q && enable_i;
  assign accept   = valid_i && ready_o;
  assign wrap     = (wcnt_q == WcntLast);
  assign tcnt_inc = tcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) state_d = StWrite;
      end
      StWrite: begin
        if (accept) begin
          wcnt_d = wrap ? '0 : wcnt_q + 1'b1;
          tcnt_d = '0;
          // A last word landing on the packet boundary was auto-committed by the FX2.
          if (last_i && !wrap) state_d = StGap;
        end else if (wcnt_q == '0) begin
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TcntLast) state_d = StGap;
        end
        if (!enable_i) state_d = (wcnt_q == '0) ? StIdle : StGap;
      end
      StGap: begin
        state_d = StPend;
      end
      StPend: begin
        wcnt_d  = '0;
        tcnt_d  = '0;
        state_d = enable_i ? StWrite : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin stage: every FX2-facing signal comes straight from a flop.
  always_comb begin
    slwr_n_d   = !accept;
    fd_o_d     = accept ? dat_i : fd_o_q;
    pktend_n_d = (state_q != StPend);
    fd_oe_d    = (state_d != StIdle);
  end

  always_ff @(posedge xIFCLK) begin
    if (RST) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      afull_q    <= 1'b0;
      slwr_n_q   <= 1'b1;
      pktend_n_q <= 1'b1;
      fd_oe_q    <= 1'b0;
      fd_o_q     <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      afull_q    <= AFULL_N;
      slwr_n_q   <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
      fd_oe_q    <= fd_oe_d;
      fd_o_q     <= fd_o_d;
    end
  end

  assign FD_O     = fd_o_q;
  assign FD_OE    = fd_oe_q;
  assign SLWR_N   = slwr_n_q;
  assign PKTEND_N = pktend_n_q;
  assign FIFOADR  = FIFOADR_IN;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_fx2_slave_fifo_writer.sv
// Directed/randomized bench for fx2_slave_fifo_writer; a word-count packet model predicts
// strobe data and PKTEND cycles.
module tb_fx2_slave_fifo_writer;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PKT_WORDS = 256;
  localparam int unsigned TIMEOUT   = 8;

  logic              clk = 1'b0;
  logic              RST;
  logic              enable_i;
  logic [DATA_W-1:0] dat_i;
  logic              valid_i;
  logic              last_i;
  logic              ready_o;
  logic [DATA_W-1:0] FD_O;
  logic              FD_OE;
  logic              SLWR_N;
  logic              PKTEND_N;
  logic [1:0]        FIFOADR;
  logic              AFULL_N;
  logic              busy_o;

  fx2_slave_fifo_writer #(
    .DATA_W    (DATA_W),
    .PKT_WORDS (PKT_WORDS),
    .TIMEOUT   (TIMEOUT),
    .FIFOADR_IN(2'b10)
  ) dut (
    .xIFCLK  (clk),
    .RST     (RST),
    .enable_i(enable_i),
    .dat_i   (dat_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .FD_O    (FD_O),
    .FD_OE   (FD_OE),
    .SLWR_N  (SLWR_N),
    .PKTEND_N(PKTEND_N),
    .FIFOADR (FIFOADR),
    .AFULL_N (AFULL_N),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   pcnt = 0;       // words in the current USB packet
  int   last_acc = 0;
  int   exp_pend[$];    // cycles at which PKTEND_N must be low
  logic acc_now = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // One clock: decide acceptance from current inputs, advance, check pins at negedge.
  task automatic step();
    logic              acc;
    logic [DATA_W-1:0] d;
    #1;
    acc = valid_i && ready_o && !RST;
    d   = dat_i;
    if (acc) begin
      last_acc = cyc;
      pcnt = (pcnt + 1) % PKT_WORDS;
      if (last_i && pcnt != 0) begin
        exp_pend.push_back(cyc + 3);
        pcnt = 0;
      end
    end
    acc_now = acc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("slwr_n", {31'd0, SLWR_N}, {31'd0, !acc});
    if (acc) chk("fd_o", {16'd0, FD_O}, {16'd0, d});
    if (SLWR_N === 1'b0) strobes++;
    if (exp_pend.size() > 0 && exp_pend[0] == cyc) begin
      chk("pktend_n", {31'd0, PKTEND_N}, 32'd0);
      void'(exp_pend.pop_front());
    end else begin
      chk("pktend_n", {31'd0, PKTEND_N}, 32'd1);
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
    bit done;
    done    = 1'b0;
    valid_i = 1'b1;
    dat_i   = d;
    last_i  = l;
    for (int i = 0; i < 64 && !done; i++) begin
      step();
      done = acc_now;
    end
    chk("accept_in_time", {31'd0, done}, 32'd1);
  endtask

  task automatic send_stream(input int n, input bit with_last, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles && i != 0) begin
        int b;
        b = $urandom_range(2, 0);
        for (int k = 0; k < b; k++) begin
          valid_i = 1'b0;
          last_i  = 1'($urandom_range(1, 0));
          dat_i   = DATA_W'($urandom);
          step();
        end
      end
      send_word(DATA_W'($urandom), with_last && (i == n - 1));
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  initial begin
    int s0;
    int d;
    RST = 1'b1; enable_i = 1'b0; dat_i = '0; valid_i = 1'b0; last_i = 1'b0; AFULL_N = 1'b1;
    @(negedge clk);
    repeat (3) step();
    chk("rst_fd_oe", {31'd0, FD_OE}, 32'd0);
    chk("rst_fd_o", {16'd0, FD_O}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_fifoadr", {30'd0, FIFOADR}, 32'd2);
    RST = 1'b0;
    step();
    chk("idle_ready", {31'd0, ready_o}, 32'd0);
    enable_i = 1'b1;
    step();
    chk("write_busy", {31'd0, busy_o}, 32'd1);
    chk("write_fd_oe", {31'd0, FD_OE}, 32'd1);
    chk("write_ready", {31'd0, ready_o}, 32'd1);

    // Short packet ended by last.
    s0 = strobes;
    for (int i = 1; i <= 10; i++) send_word(DATA_W'(i), i == 10);
    valid_i = 1'b0; last_i = 1'b0;
    repeat (4) step();
    chk("short_strobes", strobes - s0, 10);
    chk("short_pend_done", exp_pend.size(), 0);

    // Exact multiples of the packet size: no PKTEND.
    s0 = strobes;
    send_stream(256, 1'b1, 1'b1);
    repeat (4) step();
    chk("pkt256_strobes", strobes - s0, 256);
    s0 = strobes;
    send_stream(512, 1'b1, 1'b0);
    repeat (TIMEOUT + 4) step();
    chk("pkt512_strobes", strobes - s0, 512);
    chk("pkt_no_pend", exp_pend.size(), 0);

    // Idle timeout mid-packet.
    send_stream(5, 1'b0, 1'b0);
    exp_pend.push_back(last_acc + TIMEOUT + 2);
    pcnt = 0;
    repeat (TIMEOUT + 4) step();
    chk("timeout_pend_done", exp_pend.size(), 0);
    chk("timeout_busy", {31'd0, busy_o}, 32'd1);

    // Almost-full throttling.
    s0 = strobes;
    for (int i = 0; i < 3; i++) send_word(DATA_W'($urandom), 1'b0);
    AFULL_N = 1'b0;
    send_word(DATA_W'($urandom), 1'b0);
    dat_i = DATA_W'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("afull_ready_low", {31'd0, ready_o}, 32'd0);
      step();
      chk("afull_no_accept", {31'd0, acc_now}, 32'd0);
    end
    AFULL_N = 1'b1;
    chk("afull_lag_ready", {31'd0, ready_o}, 32'd0);
    step();
    chk("afull_resume_ready", {31'd0, ready_o}, 32'd1);
    for (int i = 4; i < 10; i++) send_word(DATA_W'($urandom), i == 9);
    valid_i = 1'b0; last_i = 1'b0;
    repeat (4) step();
    chk("afull_strobes", strobes - s0, 10);
    chk("afull_pend_done", exp_pend.size(), 0);

    // Disable mid-packet flushes.
    send_stream(7, 1'b0, 1'b0);
    enable_i = 1'b0;
    d = cyc;
    exp_pend.push_back(d + 3);
    pcnt = 0;
    step();
    chk("flush_gap_busy", {31'd0, busy_o}, 32'd1);
    chk("flush_gap_fd_oe", {31'd0, FD_OE}, 32'd1);
    step();
    step();
    chk("flush_fd_oe", {31'd0, FD_OE}, 32'd0);
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_pend_done", exp_pend.size(), 0);
    repeat (3) step();
    chk("flush_idle_ready", {31'd0, ready_o}, 32'd0);

    // Reset mid-packet.
    enable_i = 1'b1;
    step();
    send_stream(40, 1'b0, 1'b0);
    RST = 1'b1; valid_i = 1'b1; dat_i = DATA_W'($urandom);
    step();
    pcnt = 0;
    chk("mrst_fd_oe", {31'd0, FD_OE}, 32'd0);
    chk("mrst_fd_o", {16'd0, FD_O}, 32'd0);
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_ready", {31'd0, ready_o}, 32'd0);
    chk("mrst_fifoadr", {30'd0, FIFOADR}, 32'd2);
    RST = 1'b0; valid_i = 1'b0;
    repeat (3) step();
    s0 = strobes;
    send_stream(256, 1'b1, 1'b0);
    send_stream(3, 1'b1, 1'b0);
    repeat (5) step();
    chk("post_rst_strobes", strobes - s0, 259);
    chk("post_rst_pend_done", exp_pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
